// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
// Latency: none; functions are purely combinational. Backpressure: not applicable.
// Build option: none here; consumers may enable R_LEVEL_EN.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

  // Callers pass zero-extended pointers. Zero upper bits leave the low bits of either conversion unaffected.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Parameterised Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
// Latency: combinational, zero cycles. Backpressure: not applicable.
module gray_to_bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/r_ptr_empty.sv
// Read-domain pointer and empty flag of the async FIFO; R_LEVEL_EN adds level, almost-empty and sticky underflow.
// Latency: every output is a flop and updates on the r_clk edge that accepts r_inc.
// Backpressure: r_inc while r_empty is dropped, so the pointers hold and, with R_LEVEL_EN, underflow is flagged.
module r_ptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AE_THRESH  = 1
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  r_inc,
  input  logic [ADDR_WIDTH:0]   sync_gr_w_ptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   r_gr_ptr,
`ifdef R_LEVEL_EN
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  r_almost_empty,
  output logic                  r_underflow,
`endif
  output logic                  r_empty
);

  localparam int PW = ADDR_WIDTH + 1;

  if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_thresh
    $error("AE_THRESH outside 0..2^ADDR_WIDTH");
  end

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bin_next;
  logic [PW-1:0] r_gr_next;
  logic          rd_ok;
  logic          r_empty_next;

  assign rd_ok        = r_inc & ~r_empty;
  assign r_bin_next   = r_bin + PW'(rd_ok);
  assign r_gr_next    = PW'(bin2gray(32'(r_bin_next)));
  // MSB takes part in the compare, so a full FIFO (pointers a lap apart) never reads as empty.
  assign r_empty_next = (r_gr_next == sync_gr_w_ptr);
  assign r_addr       = r_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin    <= '0;
      r_gr_ptr <= '0;
      r_empty  <= 1'b1;
    end else begin
      r_bin    <= r_bin_next;
      r_gr_ptr <= r_gr_next;
      r_empty  <= r_empty_next;
    end
  end

`ifdef R_LEVEL_EN
  logic [PW-1:0] w_bin_sync;
  logic [PW-1:0] r_level_next;

  gray_to_bin #(.W(PW)) u_gray_to_bin (
    .gray (sync_gr_w_ptr),
    .bin  (w_bin_sync)
  );

  // The write pointer lags by the synchronizer, so this level can only under-report.
  assign r_level_next = w_bin_sync - r_bin_next;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_level        <= '0;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_level        <= r_level_next;
      r_almost_empty <= (r_level_next <= PW'(AE_THRESH));
      r_underflow    <= r_underflow | (r_inc & r_empty);
    end
  end
`endif

endmodule

// File: tb/tb_r_ptr_empty.sv
// Directed bench for r_ptr_empty at ADDR_WIDTH=3, AE_THRESH=1; level/underflow checks track R_LEVEL_EN.
module tb_r_ptr_empty;

  logic       r_clk = 1'b0;
  logic       r_rst_n = 1'b1;
  logic       r_inc = 1'b0;
  logic [3:0] sync_gr_w_ptr = 4'b0000;
  logic [2:0] r_addr;
  logic [3:0] r_gr_ptr;
  logic       r_empty;
`ifdef R_LEVEL_EN
  logic [3:0] r_level;
  logic       r_almost_empty;
  logic       r_underflow;
`endif

  int passed = 0;
  int total  = 0;

  // Hand-written 4-bit Gray code table.
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  always #5 r_clk = ~r_clk;

  r_ptr_empty #(.ADDR_WIDTH(3), .AE_THRESH(1)) dut (
    .r_clk          (r_clk),
    .r_rst_n        (r_rst_n),
    .r_inc          (r_inc),
    .sync_gr_w_ptr  (sync_gr_w_ptr),
    .r_addr         (r_addr),
    .r_gr_ptr       (r_gr_ptr),
`ifdef R_LEVEL_EN
    .r_level        (r_level),
    .r_almost_empty (r_almost_empty),
    .r_underflow    (r_underflow),
`endif
    .r_empty        (r_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic chk_lvl(input string tag, input logic [3:0] lvl, input logic ae);
`ifdef R_LEVEL_EN
    chk({tag, "_level"}, 32'(r_level), 32'(lvl));
    chk({tag, "_ae"}, 32'(r_almost_empty), 32'(ae));
`else
    if (lvl > 4'd8 || ae === 1'bx) chk({tag, "_lvlarg"}, 32'(lvl), 32'd0);
`endif
  endtask

  task automatic chk_uf(input string tag, input logic uf);
`ifdef R_LEVEL_EN
    chk({tag, "_uf"}, 32'(r_underflow), 32'(uf));
`else
    if (uf === 1'bx) chk({tag, "_ufarg"}, 32'(uf), 32'd0);
`endif
  endtask

  initial begin
    logic [3:0] prev_gr;

    // Power-on reset.
    #2 r_rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(r_empty), 32'd1);
    chk("rst_addr", 32'(r_addr), 32'd0);
    chk("rst_gr", 32'(r_gr_ptr), 32'd0);
    chk_lvl("rst", 4'd0, 1'b1);
    chk_uf("rst", 1'b0);
    repeat (2) @(posedge r_clk);
    @(negedge r_clk) r_rst_n = 1'b1;
    step();
    chk("idle_empty", 32'(r_empty), 32'd1);

    // Fill to three entries, then drain.
    sync_gr_w_ptr = 4'b0010;
    step();
    chk("fill_empty", 32'(r_empty), 32'd0);
    chk("fill_addr", 32'(r_addr), 32'd0);
    chk_lvl("fill", 4'd3, 1'b0);
    r_inc = 1'b1;
    step();
    chk("rd1_addr", 32'(r_addr), 32'd1);
    chk("rd1_gr", 32'(r_gr_ptr), 32'b0001);
    chk("rd1_empty", 32'(r_empty), 32'd0);
    chk_lvl("rd1", 4'd2, 1'b0);
    step();
    chk("rd2_addr", 32'(r_addr), 32'd2);
    chk("rd2_gr", 32'(r_gr_ptr), 32'b0011);
    chk("rd2_empty", 32'(r_empty), 32'd0);
    chk_lvl("rd2", 4'd1, 1'b1);
    step();
    chk("rd3_addr", 32'(r_addr), 32'd3);
    chk("rd3_gr", 32'(r_gr_ptr), 32'b0010);
    chk("rd3_empty", 32'(r_empty), 32'd1);
    chk_lvl("rd3", 4'd0, 1'b1);

    // Reads while empty are dropped and set the sticky underflow flag.
    step();
    chk("uf1_addr", 32'(r_addr), 32'd3);
    chk("uf1_gr", 32'(r_gr_ptr), 32'b0010);
    chk("uf1_empty", 32'(r_empty), 32'd1);
    chk_uf("uf1", 1'b1);
    r_inc = 1'b0;
    step();
    chk("uf2_addr", 32'(r_addr), 32'd3);
    chk_uf("uf2", 1'b1);
    step();
    chk_uf("uf3", 1'b1);

    // Asynchronous reset mid-stream.
    #2 r_rst_n = 1'b0;
    #1;
    chk("mrst_empty", 32'(r_empty), 32'd1);
    chk("mrst_addr", 32'(r_addr), 32'd0);
    chk("mrst_gr", 32'(r_gr_ptr), 32'd0);
    chk_lvl("mrst", 4'd0, 1'b1);
    chk_uf("mrst", 1'b0);
    sync_gr_w_ptr = 4'b0000;
    @(negedge r_clk) r_rst_n = 1'b1;
    step();
    chk("mrst_hold_empty", 32'(r_empty), 32'd1);

    // A full FIFO must not read as empty.
    sync_gr_w_ptr = 4'b1100;
    step();
    chk("full_empty", 32'(r_empty), 32'd0);
    chk("full_addr", 32'(r_addr), 32'd0);
    chk_lvl("full", 4'd8, 1'b0);

    // Wrap: 20 reads with the write pointer kept eight entries ahead.
    prev_gr = r_gr_ptr;
    r_inc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sync_gr_w_ptr = gtab[(i + 8) % 16];
      step();
      chk("wrap_gr", 32'(r_gr_ptr), 32'(gtab[(i + 1) % 16]));
      chk("wrap_addr", 32'(r_addr), 32'((i + 1) % 8));
      chk("wrap_1bit", 32'($countones(r_gr_ptr ^ prev_gr)), 32'd1);
      chk("wrap_empty", 32'(r_empty), 32'd0);
      prev_gr = r_gr_ptr;
    end
    chk_lvl("wrap", 4'd7, 1'b0);

    // Leave one entry: read pointer 4, write pointer 5.
    r_inc = 1'b0;
    sync_gr_w_ptr = gtab[5];
    step();
    chk("one_empty", 32'(r_empty), 32'd0);
    chk_lvl("one", 4'd1, 1'b1);

    // Read the last entry while the write pointer advances in the same cycle.
    r_inc = 1'b1;
    sync_gr_w_ptr = gtab[6];
    step();
    chk("sim_addr", 32'(r_addr), 32'd5);
    chk("sim_gr", 32'(r_gr_ptr), 32'b0111);
    chk("sim_empty", 32'(r_empty), 32'd0);
    chk_lvl("sim", 4'd1, 1'b1);
    step();
    chk("last_addr", 32'(r_addr), 32'd6);
    chk("last_empty", 32'(r_empty), 32'd1);
    r_inc = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/r_ptr_empty.md
# r_ptr_empty

Read-domain pointer and status block of the asynchronous FIFO. It consumes the two-flop-synchronised Gray write pointer and owns the read pointer. It produces:
- the binary RAM read address;
- the Gray read pointer handed to the write-domain synchronizer;
- a registered empty flag.

Optional occupancy, almost-empty and underflow status can be compiled in.

## Interface
- ADDR_WIDTH, 3: RAM address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AE_THRESH, 1: almost-empty threshold in entries (0..2^ADDR_WIDTH); only used with R_LEVEL_EN.

Ports (one clock; reset is asynchronous and active-low):
- r_clk  in  1  read-domain clock.
- r_rst_n  in  1  asynchronous active-low reset.
- r_inc  in  1  read request from consumer.
- sync_gr_w_ptr  in  ADDR_WIDTH+1  Gray write pointer, already synchronised to r_clk.
- r_addr  out  ADDR_WIDTH  RAM read address.
- r_gr_ptr  out  ADDR_WIDTH+1  registered Gray read pointer (to write-domain synchronizer).
- r_empty  out  1  registered empty flag.
- r_level  out  ADDR_WIDTH+1  registered occupancy 0..2^ADDR_WIDTH (R_LEVEL_EN only).
- r_almost_empty  out  1  registered, r_level <= AE_THRESH (R_LEVEL_EN only).
- r_underflow  out  1  sticky underflow flag (R_LEVEL_EN only).

## Operation
- State: r_bin (ADDR_WIDTH+1 binary), r_gr_ptr, r_empty, plus r_level, r_almost_empty and r_underflow when enabled.
- Reset values: r_bin=0, r_gr_ptr=0, r_empty=1, r_level=0, r_almost_empty=1, r_underflow=0. Consequently r_addr=0.
- Read acceptance: rd_ok = r_inc & ~r_empty. A read while empty is ignored; pointers do not move.
- Next-state values:
  - r_bin_next = r_bin + rd_ok, wrapping modulo 2^(ADDR_WIDTH+1).
  - r_gr_next = r_bin_next ^ (r_bin_next >> 1).
  - r_empty_next = (r_gr_next == sync_gr_w_ptr), full-width compare including MSB.
- r_addr = r_bin[ADDR_WIDTH-1:0], taken directly from the register with no logic after it.
- r_gr_ptr must come straight from a flop, with no combinational logic, because it crosses clock domains.
- Level calculation:
  - w_bin_sync = Gray-to-binary of sync_gr_w_ptr.
  - r_level_next = (w_bin_sync - r_bin_next) mod 2^(ADDR_WIDTH+1).
- Simultaneous read and sync-pointer change in one cycle: both are used in the same next-state calculation; no priority is needed.
- Wrap-around: the pointer MSB toggles every 2^ADDR_WIDTH reads. Empty requires an MSB match, so a full FIFO never reads as empty.
- Reset mid-operation: all state returns to its reset values immediately (asynchronously). Reset release is synchronised externally.

## Timing
- r_inc accepted at edge k: r_addr, r_gr_ptr, r_empty and r_level all update at edge k (registered, no combinational output paths).
- Read-to-empty latency: reading the last entry asserts r_empty at the same edge k. The consumer must not assert r_inc on the next cycle expecting data.
- Write-to-not-empty latency: r_empty deasserts on the first r_clk edge after sync_gr_w_ptr changes. From a write-domain Gray pointer change this is 3 r_clk edges, including the 2 synchronizer edges.
- r_level is pessimistic: it lags true occupancy by the synchronizer latency and never over-reports.

## Configuration
- R_LEVEL_EN defined: r_level, r_almost_empty and r_underflow exist and behave as specified above.
  - r_underflow sets on any cycle with r_inc & r_empty.
  - It stays set until reset.
- R_LEVEL_EN undefined:
  - those three ports and their logic are absent;
  - the Gray-to-binary converter is not instantiated;
  - pointer and empty behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - the default ADDR_WIDTH constant;
  - bin2gray and gray2bin functions;
  - the pointer-width localparam expression (ADDR_WIDTH+1).
- One sub-module: gray_to_bin, a parameterised XOR-prefix converter that turns sync_gr_w_ptr into w_bin_sync. It is instantiated only under R_LEVEL_EN.

## Test plan
All cases use ADDR_WIDTH=3 and AE_THRESH=1.
- Reset: assert r_rst_n=0 mid-stream -> immediately r_empty=1, r_addr=0, r_gr_ptr=0000, r_level=0, r_almost_empty=1, r_underflow=0.
- Fill then drain: set sync_gr_w_ptr to Gray(3)=0010, then pulse r_inc three times.
  - r_empty is 0 one edge after the pointer change.
  - r_addr steps 0,1,2,3.
  - r_level steps 3,2,1,0.
  - r_empty=1 at the edge of the third read.
  - r_almost_empty=1 once r_level<=1.
- Underflow: r_inc=1 while empty for 2 cycles -> r_bin unchanged, r_underflow=1 and stays 1 until reset.
- Wrap: stream 20 reads against a write pointer that runs ahead.
  - r_gr_ptr sequence is valid Gray, one bit change per read.
  - After 16 reads r_gr_ptr=0000 again.
  - r_addr wraps 7->0.
- Full not empty: sync_gr_w_ptr=Gray(8)=1100 with r_bin=0 -> r_empty=0, r_level=8.
- Simultaneous events: read of the last entry in the same cycle sync_gr_w_ptr advances by 1 -> r_empty stays 0, r_level stays 1.
